// File: rtl/a_reg_issue_writeback_pkg.sv
// Shared definitions for the A-register issue/writeback slice.
// Holds opcodes, unit latency and the writeback tag carried alongside in-flight ops.
package a_unit_pkg;

    localparam int NREG     = 8;
    localparam int IDX_W    = 3;
    localparam int UNIT_LAT = 6;

    localparam logic [6:0] OP_NOP   = 7'o000;
    localparam logic [6:0] OP_ASUM  = 7'o020;
    localparam logic [6:0] OP_ADIFF = 7'o021;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] dest;
    } wb_tag_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_ASUM) || (op == OP_ADIFF);
    endfunction

endpackage

// File: rtl/a_reg_issue_writeback_if.sv
// Issue, sum/diff unit, external write and status signals of the A-register block.
// The master side is whoever drives requests and plays the arithmetic unit.
interface a_reg_issue_writeback_if #(parameter int SIZE = 32);
    import a_unit_pkg::*;

    logic             i_Issue_Vld;
    logic             o_Issue_Rdy;
    logic [6:0]       i_Instr;
    logic [IDX_W-1:0] i_I;
    logic [IDX_W-1:0] i_J;
    logic [IDX_W-1:0] i_K;
    logic [SIZE-1:0]  o_Aj;
    logic [SIZE-1:0]  o_Ak;
    logic [6:0]       o_Instr;
    logic [SIZE-1:0]  i_Ai;
    logic             i_Ext_We;
    logic [IDX_W-1:0] i_Ext_Addr;
    logic [SIZE-1:0]  i_Ext_Data;
    logic             o_Ext_Ack;
    logic [NREG-1:0]  o_Resv;
    logic             o_Illegal;

    modport master (
        output i_Issue_Vld, i_Instr, i_I, i_J, i_K, i_Ai, i_Ext_We, i_Ext_Addr, i_Ext_Data,
        input  o_Issue_Rdy, o_Aj, o_Ak, o_Instr, o_Ext_Ack, o_Resv, o_Illegal
    );

    modport slave (
        input  i_Issue_Vld, i_Instr, i_I, i_J, i_K, i_Ai, i_Ext_We, i_Ext_Addr, i_Ext_Data,
        output o_Issue_Rdy, o_Aj, o_Ak, o_Instr, o_Ext_Ack, o_Resv, o_Illegal
    );

endinterface

// File: rtl/a_reg_issue_writeback_tag_pipe.sv
// Fixed-depth shift pipe of writeback tags that tracks ops through a fixed-latency unit.
// Clearing it on reset discards every in-flight result.
module a_wb_tag_pipe
    import a_unit_pkg::*;
#(
    parameter int DEPTH = UNIT_LAT + 1
) (
    input  logic    clk,
    input  logic    rst,
    input  wb_tag_t tag_in,
    output wb_tag_t tag_out
);

    wb_tag_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                stages[s] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int s = 1; s < DEPTH; s++) begin
                stages[s] <= stages[s-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/a_reg_issue_writeback.sv
// Eight A registers with reservation-based issue of add/subtract ops to the
// sum/diff unit, fixed-latency writeback and a secondary external write port.
module a_reg_issue_writeback
    import a_unit_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    a_reg_issue_writeback_if.slave   bus
);

    logic [SIZE-1:0] a_regs [NREG];
    logic [NREG-1:0] resv;
    logic [SIZE-1:0] aj_q;
    logic [SIZE-1:0] ak_q;
    logic [6:0]      instr_q;
    logic            illegal_q;

    logic            issue_rdy;
    logic            issue_legal;
    logic            ext_ack;
    wb_tag_t         push_tag;
    wb_tag_t         wb_tag;

    // No bypass: any reserved source or destination holds the issue off.
    assign issue_rdy   = bus.i_Issue_Vld && !resv[bus.i_J] && !resv[bus.i_K] && !resv[bus.i_I];
    assign issue_legal = is_legal_op(bus.i_Instr);
    assign ext_ack     = bus.i_Ext_We && !resv[bus.i_Ext_Addr]
                         && !(issue_rdy && issue_legal && (bus.i_I == bus.i_Ext_Addr));

    assign push_tag.valid = issue_rdy && issue_legal;
    assign push_tag.dest  = bus.i_I;

    a_wb_tag_pipe #(
        .DEPTH (UNIT_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (push_tag),
        .tag_out (wb_tag)
    );

    // Writeback and external writes never collide: an external write needs an
    // unreserved target while a writeback target is always reserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                a_regs[r] <= '0;
            end
            resv      <= '0;
            aj_q      <= '0;
            ak_q      <= '0;
            instr_q   <= OP_NOP;
            illegal_q <= 1'b0;
        end else begin
            if (wb_tag.valid) begin
                a_regs[wb_tag.dest] <= bus.i_Ai;
                resv[wb_tag.dest]   <= 1'b0;
            end
            if (ext_ack) begin
                a_regs[bus.i_Ext_Addr] <= bus.i_Ext_Data;
            end
            instr_q   <= OP_NOP;
            illegal_q <= 1'b0;
            if (issue_rdy) begin
                aj_q <= a_regs[bus.i_J];
                ak_q <= a_regs[bus.i_K];
                if (issue_legal) begin
                    resv[bus.i_I] <= 1'b1;
                    instr_q       <= bus.i_Instr;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_Issue_Rdy = issue_rdy;
    assign bus.o_Ext_Ack   = ext_ack;
    assign bus.o_Aj        = aj_q;
    assign bus.o_Ak        = ak_q;
    assign bus.o_Instr     = instr_q;
    assign bus.o_Resv      = resv;
    assign bus.o_Illegal   = illegal_q;

endmodule

// File: doc/a_reg_issue_writeback.md
Name: a_reg_issue_writeback

Overview:
- Owns the eight 32-bit A registers and issues 020/021 (add/subtract) operations to the address sum/diff unit.
- Reads Aj and Ak, registers them as operands for the unit, and reserves the destination Ai.
- Writes the unit's result back to Ai after the unit's fixed latency, then releases the reservation.
- A secondary write port lets the memory/transmit path load A registers.

Parameters:
- SIZE, 32, A register and datapath width.
- NREG, 8, number of A registers (index width 3).
- UNIT_LAT, 6, clock edges from operands being driven to the unit until its result is valid on i_Ai.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- i_Issue_Vld  input  1  issue request this cycle
- o_Issue_Rdy  output  1  issue accepted this cycle (combinational)
- i_Instr  input  7  opcode; legal values 7'o020 and 7'o021
- i_I, i_J, i_K  input  3 each  destination and source register indices
- o_Aj, o_Ak  output  SIZE each  registered operands to the sum/diff unit
- o_Instr  output  7  registered opcode to the unit; 7'o000 when idle
- i_Ai  input  SIZE  result from the sum/diff unit
- i_Ext_We  input  1  external write request
- i_Ext_Addr  input  3  external write register index
- i_Ext_Data  input  SIZE  external write data
- o_Ext_Ack  output  1  external write performed this edge (combinational)
- o_Resv  output  NREG  reservation bit per A register
- o_Illegal  output  1  one-cycle pulse after an illegal opcode is accepted

Behaviour:
- Reset: A[0..7]=0, o_Resv=0, all writeback-pipe valid bits=0, o_Aj=o_Ak=0, o_Instr=7'o000, o_Illegal=0.
  - Any result already in flight inside the unit is discarded.
  - The unit itself has no reset, so its output is ignored until a tagged slot matures.
- Accept rule: o_Issue_Rdy = i_Issue_Vld && !resv[i_J] && !resv[i_K] && !resv[i_I]. A source equal to the destination is allowed.
- On an accepted legal opcode, at edge t0:
  - o_Aj <= A[i_J], o_Ak <= A[i_K], o_Instr <= i_Instr.
  - resv[i_I] <= 1.
  - Push {valid=1, dest=i_I} into a writeback shift pipe of depth UNIT_LAT+1.
- On an accepted illegal opcode: nothing is reserved, a bubble enters the pipe, o_Instr <= 7'o000, o_Illegal pulses for the next cycle.
- No accept: o_Instr <= 7'o000, a bubble enters the pipe; o_Aj and o_Ak hold their values.
- Writeback: at edge t0+UNIT_LAT+1 the pipe tail is valid, so A[dest] <= i_Ai and resv[dest] <= 0.
  - Issue-to-writeback latency is 7 edges at default parameters.
  - At most one writeback per edge, because latency is fixed.
- Throughput: one issue per cycle when there are no hazards. Multiple operations can be in flight to distinct destinations.
- Hazards:
  - A read of a reserved register stalls (o_Issue_Rdy=0). There is no bypass.
  - The reservation clears at the writeback edge, so an issue in the following cycle reads the new value.
  - A writeback and an issue that both target register X in the same cycle: the issue stalls, because resv[X] is still 1 during that cycle.
- External write: o_Ext_Ack = i_Ext_We && !resv[i_Ext_Addr] && !(o_Issue_Rdy && legal && i_I==i_Ext_Addr).
  - On ack, A[i_Ext_Addr] <= i_Ext_Data.
  - An unacked requester must hold its request.
- External write to a register read by a same-cycle issue: the issue captures the old value.
- Arithmetic: none in this block. Width is SIZE throughout, with no overflow handling.
- Reset mid-operation: everything is cleared as above, and no writeback occurs on or after the reset edge.

Decomposition:
- Shared package a_unit_pkg holds:
  - opcode constants OP_ASUM=7'o020, OP_ADIFF=7'o021, OP_NOP=7'o000
  - UNIT_LAT and register-index width
  - writeback tag struct {valid, dest[2:0]}
- One sub-module, a_wb_tag_pipe: a parameterized shift pipe of tags with synchronous clear. It is reused for future address multiply issue.
- Register file, reservation vector and arbitration stay in the top level.

Test Plan:
- Basic add: preload A1=5, A2=7 via ext port; issue 020 i=3 j=1 k=2.
  - o_Aj=5, o_Ak=7 and o_Instr=020 in cycle t0+1.
  - A3=12 and resv[3]=0 after edge t0+7.
- Subtract wrap: A1=0, A2=1; issue 021 i=4 j=1 k=2.
  - A4=32'hFFFFFFFF after 7 edges.
- RAW stall: issue 020 i=3, then immediately 020 i=5 j=3 k=3.
  - Second issue held with o_Issue_Rdy=0 until the cycle after A3 writes back, then reads the new A3.
- Back-to-back throughput: 7 consecutive independent issues with i=1..7 from preloaded A0=1.
  - One writeback per edge, with results in issue order.
- Ext conflict: ext write to reserved A3 → o_Ext_Ack=0 until the writeback edge passes, then acked next cycle.
  - Ext write to i_I in the same cycle as a legal issue → not acked.
- Reset mid-flight: assert rst 3 cycles after an issue to A6.
  - A6 stays 0, o_Resv=0, no writeback ever occurs.
  - Illegal opcode 7'o077 accepted afterwards → o_Illegal pulses once, nothing is reserved.
